// File: rtl/lfsr_burst_gen.sv
// Burst generator: loads a seed on request and streams (req_count+1) Galois-LFSR words
// over a val/rdy interface, with backpressure and mid-burst abort.
module lfsr_burst_gen #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TAPS     = 32'h80200003,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] ZERO_SUB = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] req_seed,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_last,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               done_q, done_d;

  // Right-shift Galois step; the feedback mask is applied when the bit shifted out is 1.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : {WIDTH{1'b0}});
  endfunction

  // Next-state logic for the IDLE/RUN controller, LFSR and burst counter.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          // An all-zero seed would lock the LFSR, so a nonzero substitute is loaded instead.
          lfsr_d      = (req_seed == {WIDTH{1'b0}}) ? ZERO_SUB : req_seed;
          remaining_d = req_count;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (resp_rdy) begin
          if (remaining_q == {CNT_W{1'b0}}) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            lfsr_d      = lfsr_step(lfsr_q);
            remaining_d = remaining_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= ZERO_SUB;
      remaining_q <= {CNT_W{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Handshake outputs; abort masks resp_val so no word transfers in the abort cycle.
  always_comb begin
    req_rdy   = (state_q == ST_IDLE);
    resp_val  = (state_q == ST_RUN) && !abort;
    resp_data = lfsr_q;
    resp_last = resp_val && (remaining_q == {CNT_W{1'b0}});
    done      = done_q;
  end

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Scoreboard bench for lfsr_burst_gen (WIDTH=4, TAPS=4'hC, CNT_W=4) with a table-based reference.
module tb_lfsr_burst_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [3:0] req_seed;
  logic [3:0] req_count;
  logic       abort;
  logic       resp_val;
  logic       resp_rdy;
  logic [3:0] resp_data;
  logic       resp_last;
  logic       done;

  lfsr_burst_gen #(
    .WIDTH(4), .TAPS(4'hC), .CNT_W(4), .ZERO_SUB(4'h1)
  ) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_seed(req_seed), .req_count(req_count), .abort(abort),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .resp_last(resp_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] seq [0:14] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                             4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented word against the scoreboard and tracks done.
  initial begin
    logic exp_done;
    logic took_last;
    exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_done = 1'b0;
      end else begin
        check("done", done, exp_done);
        took_last = 1'b0;
        if (resp_val) begin
          if (q.size() == 0) begin
            check("spurious_resp_val", resp_val, 1'b0);
          end else begin
            check("resp_data", resp_data, q[0].data);
            check("resp_last", resp_last, q[0].last);
            if (resp_rdy) begin
              took_last = q[0].last;
              void'(q.pop_front());
            end
          end
        end
        exp_done = took_last;
      end
    end
  end

  // One burst; called and returns at posedge+1. kill_at>=0 aborts (or resets) during that word.
  task automatic do_burst(input logic [3:0] seed, input logic [3:0] cnt, input int stall,
                          input bit rnd_rdy, input int kill_at, input bit kill_reset,
                          input bit abort_on_req);
    int idx;
    int n_sent;
    int cyc;
    idx = 0;
    for (int i = 0; i < 15; i++)
      if (seq[i] == ((seed == 4'h0) ? 4'h1 : seed)) idx = i;
    for (int k = 0; k <= int'(cnt); k++)
      q.push_back('{data: seq[(idx + k) % 15], last: (k == int'(cnt))});
    check("req_rdy_idle", req_rdy, 1'b1);
    req_val   = 1'b1;
    req_seed  = seed;
    req_count = cnt;
    abort     = abort_on_req;
    @(posedge clk); #1;
    abort     = 1'b0;
    req_seed  = 4'($urandom);
    req_count = 4'($urandom);
    check("req_rdy_busy", req_rdy, 1'b0);
    n_sent = 0;
    cyc    = 0;
    while (n_sent <= int'(cnt)) begin
      if (cyc >= 1000) begin
        check("burst_timeout", 32'(cyc), 32'd0);
        break;
      end
      if (n_sent == kill_at) begin
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        if (kill_reset) begin
          @(negedge clk); #2;
          reset = 1'b0;
          #1;
          check("rst_resp_val", resp_val, 1'b0);
          check("rst_req_rdy", req_rdy, 1'b1);
          check("rst_resp_last", resp_last, 1'b0);
          q.delete();
          repeat (2) @(negedge clk);
          #2 reset = 1'b1;
        end else begin
          abort = 1'b1;
          @(negedge clk);
          check("abort_resp_val", resp_val, 1'b0);
          check("abort_resp_last", resp_last, 1'b0);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        check("kill_req_rdy", req_rdy, 1'b1);
        break;
      end
      req_val  = (cyc < stall);
      resp_rdy = (cyc < stall) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      @(posedge clk);
      if (resp_rdy) n_sent++;
      #1;
      cyc++;
    end
    req_val  = 1'b0;
    resp_rdy = 1'($urandom_range(0, 1));
    check("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kat;
    logic [3:0] rc;
    reset = 1'b0; req_val = 1'b0; req_seed = 4'h0; req_count = 4'h0;
    abort = 1'b0; resp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_rdy", req_rdy, 1'b1);
    check("reset_resp_val", resp_val, 1'b0);
    check("reset_resp_last", resp_last, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_lfsr", resp_data, 4'h1);
    reset = 1'b1;
    @(posedge clk); #1;

    do_burst(4'h1, 4'd3, 0, 1'b0, -1, 1'b0, 1'b0);
    do_burst(4'h0, 4'd1, 0, 1'b0, -1, 1'b0, 1'b0);
    do_burst(4'hD, 4'd2, 3, 1'b0, -1, 1'b0, 1'b0);
    do_burst(4'h1, 4'd15, 0, 1'b0, -1, 1'b0, 1'b0);
    do_burst(4'h1, 4'd7, 0, 1'b0, 2, 1'b0, 1'b0);
    do_burst(4'h5, 4'd2, 0, 1'b0, -1, 1'b0, 1'b1);
    do_burst(4'($urandom), 4'd10, 0, 1'b0, 3, 1'b1, 1'b0);
    do_burst(4'h9, 4'd4, 1, 1'b1, -1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rc  = 4'($urandom);
      kat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rc))) : -1;
      do_burst(4'($urandom), rc, int'($urandom_range(0, 2)), 1'b1, kat, 1'b0,
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
